// File: rtl/mips_cache_pkg.sv
// Shared data-cache definitions: default geometry, address field layout,
// FSM state encoding and the captured-request record.
package mips_cache_pkg;

  localparam int DC_ADDR_W     = 32;
  localparam int DC_DATA_W     = 32;
  localparam int DC_STRB_W     = DC_DATA_W / 8;
  localparam int DC_SETS       = 64;
  localparam int DC_LINE_WORDS = 4;

  // Byte address = tag | index | word | byte
  localparam int DC_OFF_W    = 2;
  localparam int DC_WORD_W   = $clog2(DC_LINE_WORDS);
  localparam int DC_IDX_W    = $clog2(DC_SETS);
  localparam int DC_TAG_W    = DC_ADDR_W - DC_OFF_W - DC_WORD_W - DC_IDX_W;
  localparam int DC_WORD_LSB = DC_OFF_W;
  localparam int DC_IDX_LSB  = DC_OFF_W + DC_WORD_W;
  localparam int DC_TAG_LSB  = DC_IDX_LSB + DC_IDX_W;

  localparam logic [2:0] KSEG1 = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    WR_REQ  = 2'd3
  } dcache_state_e;

  typedef struct packed {
    logic                 write;
    logic [DC_ADDR_W-1:0] addr;
    logic [DC_DATA_W-1:0] wdata;
    logic [DC_STRB_W-1:0] wstrb;
  } dcache_req_t;

  function automatic logic is_kseg1(input logic [DC_ADDR_W-1:0] addr);
    return addr[DC_ADDR_W-1 -: 3] == KSEG1;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped tag/valid/data storage in flops: combinational read of one
// word plus its line's tag/valid, byte-strobed word write, tag/valid update.
module dcache_array #(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 24
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [$clog2(SETS)-1:0]       i_rd_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] i_rd_word,
  output logic                          o_rd_valid,
  output logic [TAG_W-1:0]              o_rd_tag,
  output logic [DATA_W-1:0]             o_rd_data,
  input  logic                          i_wr_en,
  input  logic [$clog2(SETS)-1:0]       i_wr_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] i_wr_word,
  input  logic [DATA_W-1:0]             i_wr_data,
  input  logic [DATA_W/8-1:0]           i_wr_strb,
  input  logic                          i_set_en,
  input  logic [$clog2(SETS)-1:0]       i_set_idx,
  input  logic                          i_set_valid,
  input  logic [TAG_W-1:0]              i_set_tag
);

  localparam int IDX_W  = $clog2(SETS);
  localparam int WORD_W = $clog2(LINE_WORDS);

  logic [SETS-1:0]   r_valid;
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [DATA_W-1:0] r_data [SETS*LINE_WORDS];

  logic [IDX_W+WORD_W-1:0] w_rd_ptr;
  logic [IDX_W+WORD_W-1:0] w_wr_ptr;

  assign w_rd_ptr   = {i_rd_idx, i_rd_word};
  assign w_wr_ptr   = {i_wr_idx, i_wr_word};
  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[w_rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else if (i_set_en) begin
      r_valid[i_set_idx] <= i_set_valid;
    end
  end

  // Tags and data need no reset: nothing is trusted until its valid bit is set.
  always_ff @(posedge i_clk) begin
    if (i_set_en && i_set_valid) begin
      r_tag[i_set_idx] <= i_set_tag;
    end
    if (i_wr_en) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (i_wr_strb[b]) begin
          r_data[w_wr_ptr][b*8 +: 8] <= i_wr_data[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache between the MEM
// stage and a single-outstanding memory bus; kseg1 accesses bypass the array.
module dcache_wt
  import mips_cache_pkg::*;
#(
  parameter int ADDR_W     = DC_ADDR_W,
  parameter int DATA_W     = DC_DATA_W,
  parameter int SETS       = DC_SETS,
  parameter int LINE_WORDS = DC_LINE_WORDS
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_write,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic [DATA_W-1:0]   i_req_wdata,
  input  logic [DATA_W/8-1:0] i_req_wstrb,
  output logic                o_resp_valid,
  output logic [DATA_W-1:0]   o_resp_rdata,
  output logic                o_mem_req_valid,
  input  logic                i_mem_req_ready,
  output logic                o_mem_req_write,
  output logic                o_mem_req_burst,
  output logic [ADDR_W-1:0]   o_mem_req_addr,
  output logic [DATA_W-1:0]   o_mem_req_wdata,
  output logic [DATA_W/8-1:0] o_mem_req_wstrb,
  input  logic                i_mem_resp_valid,
  input  logic [DATA_W-1:0]   i_mem_resp_rdata,
  output dcache_state_e       o_dbg_state
);

  localparam int WORD_W  = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(SETS);
  localparam int IDX_LSB = 2 + WORD_W;
  localparam int TAG_LSB = IDX_LSB + IDX_W;
  localparam int TAG_W   = ADDR_W - TAG_LSB;

  dcache_state_e     r_state, w_next;
  dcache_req_t       r_req;
  logic              r_uncached;
  logic              r_burst;
  logic [WORD_W:0]   r_beat;
  logic [DATA_W-1:0] r_fill_word;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;

  logic [IDX_W-1:0]  w_in_idx, w_cap_idx, w_rd_idx;
  logic [WORD_W-1:0] w_in_word, w_cap_word, w_rd_word;
  logic [TAG_W-1:0]  w_in_tag, w_cap_tag, w_rd_tag;
  logic              w_in_unc, w_rd_valid, w_in_hit, w_cap_hit;
  logic [DATA_W-1:0] w_rd_data, w_rd_sel;
  logic              w_load_hit, w_miss_accept, w_rd_done, w_wr_done;
  logic              w_last_beat, w_refill_beat, w_unused;

  assign w_in_idx   = i_req_addr[IDX_LSB +: IDX_W];
  assign w_in_word  = i_req_addr[2 +: WORD_W];
  assign w_in_tag   = i_req_addr[ADDR_W-1:TAG_LSB];
  assign w_in_unc   = is_kseg1(i_req_addr);
  assign w_cap_idx  = r_req.addr[IDX_LSB +: IDX_W];
  assign w_cap_word = r_req.addr[2 +: WORD_W];
  assign w_cap_tag  = r_req.addr[ADDR_W-1:TAG_LSB];
  assign w_unused   = &{1'b0, i_req_addr[1:0], r_req.addr[1:0]};

  // The single read port looks up the incoming access in IDLE and the captured one otherwise.
  assign w_rd_idx  = (r_state == IDLE) ? w_in_idx  : w_cap_idx;
  assign w_rd_word = (r_state == IDLE) ? w_in_word : w_cap_word;
  assign w_in_hit  = w_rd_valid && (w_rd_tag == w_in_tag) && !w_in_unc;
  assign w_cap_hit = w_rd_valid && (w_rd_tag == w_cap_tag) && !r_uncached;

  assign w_last_beat   = (r_beat == (WORD_W+1)'(LINE_WORDS-1));
  assign w_refill_beat = (r_state == RD_WAIT) && i_mem_resp_valid && r_burst;
  assign w_rd_sel      = (!r_burst || (r_beat[WORD_W-1:0] == w_cap_word)) ? i_mem_resp_rdata
                                                                           : r_fill_word;

  // valid/ready: an access transfers on the edge where i_req_valid && o_req_ready;
  // a bus request transfers where o_mem_req_valid && i_mem_req_ready, and its
  // fields are held until then. Read beats have no backpressure.
  always_comb begin
    w_next          = r_state;
    o_req_ready     = 1'b0;
    o_mem_req_valid = 1'b0;
    o_mem_req_write = 1'b0;
    o_mem_req_burst = 1'b0;
    o_mem_req_addr  = '0;
    o_mem_req_wdata = '0;
    o_mem_req_wstrb = '0;
    w_load_hit      = 1'b0;
    w_miss_accept   = 1'b0;
    w_rd_done       = 1'b0;
    w_wr_done       = 1'b0;
    case (r_state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          if (i_req_write) begin
            w_next = WR_REQ;
          end else if (w_in_unc) begin
            w_next = RD_REQ;
          end else if (w_in_hit) begin
            w_load_hit = 1'b1;
          end else begin
            w_next        = RD_REQ;
            w_miss_accept = 1'b1;
          end
        end
      end
      RD_REQ: begin
        o_mem_req_valid = 1'b1;
        o_mem_req_burst = r_burst;
        o_mem_req_addr  = r_burst ? {r_req.addr[ADDR_W-1:IDX_LSB], {IDX_LSB{1'b0}}}
                                  : {r_req.addr[ADDR_W-1:2], 2'b00};
        if (i_mem_req_ready) w_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (i_mem_resp_valid && (!r_burst || w_last_beat)) begin
          w_rd_done = 1'b1;
          w_next    = IDLE;
        end
      end
      WR_REQ: begin
        o_mem_req_valid = 1'b1;
        o_mem_req_write = r_req.write;
        o_mem_req_addr  = {r_req.addr[ADDR_W-1:2], 2'b00};
        o_mem_req_wdata = r_req.wdata;
        o_mem_req_wstrb = r_req.wstrb;
        if (i_mem_req_ready) begin
          w_wr_done = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req        <= '0;
      r_uncached   <= 1'b0;
      r_burst      <= 1'b0;
      r_beat       <= '0;
      r_fill_word  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= w_load_hit | w_rd_done | w_wr_done;
      if (w_load_hit)     r_resp_rdata <= w_rd_data;
      else if (w_rd_done) r_resp_rdata <= w_rd_sel;
      else                r_resp_rdata <= '0;
      if (i_req_valid && o_req_ready) begin
        r_req      <= '{write: i_req_write, addr: i_req_addr, wdata: i_req_wdata, wstrb: i_req_wstrb};
        r_uncached <= w_in_unc;
        r_burst    <= !i_req_write && !w_in_unc;
      end
      if (w_rd_done) begin
        r_beat <= '0;
      end else if ((r_state == RD_WAIT) && i_mem_resp_valid) begin
        r_beat <= r_beat + 1'b1;
      end
      // Keep the requested word in case it arrives before the last beat.
      if ((r_state == RD_WAIT) && i_mem_resp_valid && (r_beat[WORD_W-1:0] == w_cap_word)) begin
        r_fill_word <= i_mem_resp_rdata;
      end
    end
  end

  dcache_array #(
    .SETS      (SETS),
    .LINE_WORDS(LINE_WORDS),
    .DATA_W    (DATA_W),
    .TAG_W     (TAG_W)
  ) u_array (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rd_idx   (w_rd_idx),
    .i_rd_word  (w_rd_word),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_wr_en    (w_refill_beat | (w_wr_done & w_cap_hit)),
    .i_wr_idx   (w_cap_idx),
    .i_wr_word  (w_refill_beat ? r_beat[WORD_W-1:0] : w_cap_word),
    .i_wr_data  (w_refill_beat ? i_mem_resp_rdata : r_req.wdata),
    .i_wr_strb  (w_refill_beat ? {(DATA_W/8){1'b1}} : r_req.wstrb),
    .i_set_en   (w_miss_accept | (w_rd_done & r_burst)),
    .i_set_idx  (w_miss_accept ? w_in_idx : w_cap_idx),
    .i_set_valid(!w_miss_accept),
    .i_set_tag  (w_cap_tag)
  );

  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_dbg_state  = r_state;

  a_resp_only_in_wait: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_mem_resp_valid |-> (r_state == RD_WAIT));

endmodule
